// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the register file with write-pending scoreboard.
// Holds the default geometry, the register/address/count types and the status bundle.
package reg_file_sb_pkg;

  localparam int RegAddrWidth = 5;
  localparam int RegDataWidth = 32;
  localparam int PendWidth    = 2;

  typedef logic [RegDataWidth-1:0] Register;
  typedef logic [RegAddrWidth-1:0] RegAddr;
  typedef logic [PendWidth-1:0]    PendCnt;

  typedef struct packed {
    logic issue_ok;
    logic stall;
    logic sb_err;
  } SB_status;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/write-back bus of the register file: read ports, issue, write-back and status.
// The master side is the pipeline, the slave side is the register file.
interface reg_file_sb_if
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W = RegDataWidth,
  parameter int ADDR_W = RegAddrWidth,
  parameter int NUM_RD = 2
) ();

  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     stall;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_dst;
  logic                     issue_ok;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_dst;
  logic [DATA_W-1:0]        wb_data;
  logic                     flush;
  logic                     sb_err;

  modport master (
    output rd_en, rd_addr, issue_en, issue_dst, wb_en, wb_dst, wb_data, flush,
    input  rd_data, rd_busy, stall, issue_ok, sb_err
  );

  modport slave (
    input  rd_en, rd_addr, issue_en, issue_dst, wb_en, wb_dst, wb_data, flush,
    output rd_data, rd_busy, stall, issue_ok, sb_err
  );

endinterface

// File: rtl/reg_file_sb_pend_ctr.sv
// Per-register pending-write counter: clear has priority, never wraps in either direction.
module pend_ctr #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  input  logic              clr,
  output logic [PEND_W-1:0] cnt,
  output logic              full,
  output logic              nonzero
);

  logic [PEND_W-1:0] cnt_r;

  // count register; a simultaneous inc and dec cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && !dec && !full) begin
      cnt_r <= cnt_r + PEND_W'(1);
    end else if (dec && !inc && nonzero) begin
      cnt_r <= cnt_r - PEND_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt     = cnt_r;
  assign full    = &cnt_r;
  assign nonzero = |cnt_r;

endmodule

// File: rtl/reg_file_sb.sv
// Decode-stage register file with per-register write-pending scoreboard for RAW stalls.
// Optional REGFILE_BYPASS_EN: same-cycle write-back is forwarded to reads and releases busy.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W = RegDataWidth,
  parameter int ADDR_W = RegAddrWidth,
  parameter int NUM_RD = 2,
  parameter int PEND_W = PendWidth
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_sb_if.slave bus
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0]        regs_r [NREG];
  logic [PEND_W-1:0]        cnt_s  [NREG];
  logic [NREG-1:0]          inc_s;
  logic [NREG-1:0]          dec_s;
  logic [NREG-1:0]          full_s;
  logic [NREG-1:0]          nonzero_s;
  logic                     issue_ok_s;
  logic                     err_s;
  logic                     sb_err_r;
  logic [NUM_RD-1:0]        busy_s;
  logic [NUM_RD*DATA_W-1:0] rd_data_s;
  SB_status                 status_s;

  // register 0 is hardwired: no counter, never pending
  assign cnt_s[0]     = '0;
  assign inc_s[0]     = 1'b0;
  assign dec_s[0]     = 1'b0;
  assign full_s[0]    = 1'b0;
  assign nonzero_s[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_ctr
    assign inc_s[r] = bus.issue_en & issue_ok_s & ~bus.flush & (bus.issue_dst == ADDR_W'(r));
    assign dec_s[r] = bus.wb_en & nonzero_s[r] & (bus.wb_dst == ADDR_W'(r));

    pend_ctr #(.PEND_W(PEND_W)) u_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (inc_s[r]),
      .dec     (dec_s[r]),
      .clr     (bus.flush),
      .cnt     (cnt_s[r]),
      .full    (full_s[r]),
      .nonzero (nonzero_s[r])
    );
  end

  // a full counter still accepts an issue when a write-back drains it this cycle
  assign issue_ok_s = ~(full_s[bus.issue_dst] & ~dec_s[bus.issue_dst]);

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr_s;
    assign addr_s = bus.rd_addr[p*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    logic byp_s;
    assign byp_s = bus.wb_en & (bus.wb_dst == addr_s) & (addr_s != '0);
    assign rd_data_s[p*DATA_W +: DATA_W] = byp_s ? bus.wb_data : regs_r[addr_s];
    assign busy_s[p] = (cnt_s[addr_s] - PEND_W'(dec_s[addr_s])) != '0;
`else
    assign rd_data_s[p*DATA_W +: DATA_W] = regs_r[addr_s];
    assign busy_s[p] = cnt_s[addr_s] != '0;
`endif
  end

  // protocol errors; a flush squashes the issue and excuses a zero-count write-back
  always_comb begin
    err_s = 1'b0;
    if (bus.flush) begin
      err_s = 1'b0;
    end else if (bus.issue_en && !issue_ok_s) begin
      err_s = 1'b1;
    end else if (bus.wb_en && (bus.wb_dst != '0) && !nonzero_s[bus.wb_dst]) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // register array; entry 0 is never written so it stays zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (bus.wb_en && (bus.wb_dst != '0)) begin
      regs_r[bus.wb_dst] <= bus.wb_data;
    end
  end

  // sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_err_r <= 1'b0;
    end else if (err_s) begin
      sb_err_r <= 1'b1;
    end
  end

  assign status_s.issue_ok = issue_ok_s;
  assign status_s.stall    = |(bus.rd_en & busy_s);
  assign status_s.sb_err   = sb_err_r;

  assign bus.rd_data  = rd_data_s;
  assign bus.rd_busy  = busy_s;
  assign bus.issue_ok = status_s.issue_ok;
  assign bus.stall    = status_s.stall;
  assign bus.sb_err   = status_s.sb_err;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: expectations are queued as each cycle is driven
// and compared when the outputs are sampled on the falling edge.
module tb_reg_file_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  busy;
    logic        stall;
    logic        ok;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  exp_t  exp_q[$];
  string tag_q[$];

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

  reg_file_sb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic set_in(input bit ie, input logic [4:0] idst, input bit we,
                        input logic [4:0] wdst, input logic [31:0] wd, input bit fl);
    bus.issue_en  = ie;
    bus.issue_dst = idst;
    bus.wb_en     = we;
    bus.wb_dst    = wdst;
    bus.wb_data   = wd;
    bus.flush     = fl;
  endtask

  task automatic set_rd(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_en   = en;
    bus.rd_addr = {a1, a0};
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // queue the expectation for the cycle just driven, then compare at the falling edge
  task automatic apply_vec(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [1:0] busy, input logic stall, input logic ok,
                           input logic err);
    exp_t e;
    string t;
    e = '{d0: d0, d1: d1, busy: busy, stall: stall, ok: ok, err: err};
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_val({t, ".d0"},    64'(bus.rd_data[31:0]),  64'(e.d0));
    check_val({t, ".d1"},    64'(bus.rd_data[63:32]), 64'(e.d1));
    check_val({t, ".busy"},  64'(bus.rd_busy),        64'(e.busy));
    check_val({t, ".stall"}, 64'(bus.stall),          64'(e.stall));
    check_val({t, ".ok"},    64'(bus.issue_ok),       64'(e.ok));
    check_val({t, ".err"},   64'(bus.sb_err),         64'(e.err));
  endtask

  task automatic pulse_reset();
    next_cycle();
    rst_n = 1'b0;
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    set_rd(2'b01, 5'd5, 5'd0);
    apply_vec("rst_hold", 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b1;

    // reset then read r5
    next_cycle();
    apply_vec("t1_read", 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0);

    // issue r3, write back three cycles later
    next_cycle(); set_rd(2'b01, 5'd3, 5'd0); set_in(1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0);
    apply_vec("t2_issue", 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    next_cycle(); set_in(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    apply_vec("t2_c1", 32'd0, 32'd0, 2'b01, 1'b1, 1'b1, 1'b0);
    next_cycle();
    apply_vec("t2_c2", 32'd0, 32'd0, 2'b01, 1'b1, 1'b1, 1'b0);
    next_cycle(); set_in(1'b0, 5'd0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0);
    apply_vec("t2_wb", BYP ? 32'hDEADBEEF : 32'd0, 32'd0, BYP ? 2'b00 : 2'b01, !BYP, 1'b1, 1'b0);
    next_cycle(); set_in(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    apply_vec("t2_after", 32'hDEADBEEF, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0);

    // saturate r7
    set_rd(2'b01, 5'd7, 5'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); set_in(1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0);
      apply_vec($sformatf("t3_issue%0d", i), 32'd0, 32'd0, (i == 0) ? 2'b00 : 2'b01,
                i != 0, 1'b1, 1'b0);
    end
    next_cycle();
    apply_vec("t3_full", 32'd0, 32'd0, 2'b01, 1'b1, 1'b0, 1'b0);
    next_cycle(); set_in(1'b1, 5'd7, 1'b1, 5'd7, 32'h77, 1'b0);
    apply_vec("t3_iss_wb", BYP ? 32'h77 : 32'd0, 32'd0, 2'b01, 1'b1, 1'b1, 1'b1);
    next_cycle(); set_in(1'b0, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0);
    apply_vec("t3_still3", 32'h77, 32'd0, 2'b01, 1'b1, 1'b0, 1'b1);

    // write-back with zero count
    pulse_reset();
    set_rd(2'b01, 5'd9, 5'd0);
    set_in(1'b0, 5'd0, 1'b1, 5'd9, 32'h1234, 1'b0);
    apply_vec("t4_wb", BYP ? 32'h1234 : 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    next_cycle(); set_in(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    apply_vec("t4_after", 32'h1234, 32'd0, 2'b00, 1'b0, 1'b1, 1'b1);

    // flush with a same-cycle issue and zero-count write-back
    pulse_reset();
    set_rd(2'b11, 5'd4, 5'd6);
    set_in(1'b1, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0);
    apply_vec("t5_iss4", 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    next_cycle(); set_in(1'b1, 5'd6, 1'b0, 5'd0, 32'd0, 1'b0);
    apply_vec("t5_iss6", 32'd0, 32'd0, 2'b01, 1'b1, 1'b1, 1'b0);
    next_cycle(); set_in(1'b1, 5'd8, 1'b1, 5'd10, 32'hABC, 1'b1);
    apply_vec("t5_flush", 32'd0, 32'd0, 2'b11, 1'b1, 1'b1, 1'b0);
    next_cycle(); set_in(1'b0, 5'd8, 1'b0, 5'd0, 32'd0, 1'b0); set_rd(2'b11, 5'd8, 5'd10);
    apply_vec("t5_r8", 32'd0, 32'hABC, 2'b00, 1'b0, 1'b1, 1'b0);
    next_cycle(); set_rd(2'b11, 5'd4, 5'd6);
    apply_vec("t5_clear", 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0);

    // register 0
    next_cycle(); set_rd(2'b01, 5'd0, 5'd0); set_in(1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    apply_vec("t6_wb0", 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    next_cycle(); set_in(1'b1, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    apply_vec("t6_iss0", 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    next_cycle(); set_in(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    apply_vec("t6_r0", 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0);

    // reset mid-stream with r2 pending
    next_cycle(); set_rd(2'b01, 5'd2, 5'd0); set_in(1'b1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0);
    apply_vec("t6_iss2", 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    next_cycle(); set_in(1'b0, 5'd0, 1'b1, 5'd2, 32'h55, 1'b0);
    apply_vec("t6_wb2", BYP ? 32'h55 : 32'd0, 32'd0, BYP ? 2'b00 : 2'b01, !BYP, 1'b1, 1'b0);
    next_cycle(); set_in(1'b1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0);
    apply_vec("t6_reiss2", 32'h55, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    next_cycle(); set_in(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    apply_vec("t6_pend2", 32'h55, 32'd0, 2'b01, 1'b1, 1'b1, 1'b0);
    next_cycle(); rst_n = 1'b0;
    apply_vec("t6_rst", 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    next_cycle(); rst_n = 1'b1;
    apply_vec("t6_post", 32'd0, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file with an integrated write-pending scoreboard.
- Generalises the 32x32 pipeline register file: configurable data width, address width and number of read ports.
- Tracks in-flight writes per register so decode can stall on RAW hazards without comparing stage-by-stage addresses.
- Sits in the decode stage. Issue comes from D. Write-back comes from the WB stage.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; 2**ADDR_W registers
NUM_RD, 2, number of read ports (rs, rt, ...)
PEND_W, 2, pending-counter width; max in-flight writes per register = 2**PEND_W-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rd_en  in  NUM_RD  per-port read valid; only enabled ports contribute to stall
rd_addr  in  NUM_RD*ADDR_W  packed read addresses, port 0 in LSBs
rd_data  out  NUM_RD*DATA_W  packed read data
rd_busy  out  NUM_RD  per-port register has a pending write
stall  out  1  OR of (rd_en & rd_busy)
issue_en  in  1  D issues an instruction writing issue_dst
issue_dst  in  ADDR_W  destination of issued instruction
issue_ok  out  1  issue will be accepted this cycle
wb_en  in  1  write-back valid
wb_dst  in  ADDR_W  write-back destination
wb_data  in  DATA_W  write-back value
flush  in  1  clear all pending counts (branch/jump squash)
sb_err  out  1  sticky protocol error flag

Behaviour:
- Reset (async, rst_n=0):
  - All registers are 0.
  - All pending counts are 0.
  - sb_err is 0.
  - Outputs follow from the cleared state: rd_busy=0, stall=0, issue_ok=1.
  - Reset mid-operation discards all in-flight state immediately.
- Register 0:
  - Always reads 0.
  - Never pending; rd_busy for address 0 is always 0.
  - Writes to it are ignored.
  - issue_dst=0 is accepted (issue_ok=1) but does not change any count.
- Write:
  - On the rising edge with wb_en=1 and wb_dst!=0, reg[wb_dst] <= wb_data.
- Read:
  - Combinational from rd_addr.
  - Bypass: if wb_en, wb_dst==rd_addr and rd_addr!=0, rd_data returns wb_data in the same cycle.
- Pending count cnt[r], PEND_W bits, per register r:
  - inc = issue_en & issue_ok & (issue_dst==r) & (r!=0).
  - dec = wb_en & (wb_dst==r) & (cnt[r]!=0).
  - Next count: cnt + inc - dec. Simultaneous inc and dec on the same register leaves cnt unchanged.
- Busy:
  - rd_busy[p] = (cnt[a] - dec_a) != 0, where a = rd_addr[p].
  - A write-back arriving this cycle therefore releases the stall in the same cycle (paired with bypass).
- issue_ok:
  - 0 only when cnt[issue_dst] == 2**PEND_W-1 and there is no same-cycle dec on that register.
  - issue_en while issue_ok=0 is dropped and sets sb_err.
- Write-back to a register with cnt==0 (and wb_dst!=0):
  - The data write still occurs.
  - cnt stays at 0 (no underflow).
  - sb_err is set.
- flush:
  - All cnt <= 0 on the next edge.
  - A same-cycle issue is dropped, with no error.
  - A same-cycle wb data write still occurs, with no error for a zero count.
- sb_err is sticky until reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Same-cycle write-to-read bypass as above.
  - rd_busy subtracts the same-cycle dec.
- Undefined:
  - Reads return the stored value only; new data is visible the cycle after write-back.
  - rd_busy = (cnt[a] != 0), so the stall is held one extra cycle.
  - All other behaviour is identical.

Decomposition:
- Shared package (definitions): RegAddrWidth, Register, RegAddr, a new PendCnt typedef (logic[PEND_W-1:0]), and a packed SB_status struct {issue_ok, stall, sb_err}.
- One sub-module, pend_ctr:
  - Per-register saturating up/down counter with inputs inc, dec, clr and outputs cnt, full, nonzero.
  - Instantiated 2**ADDR_W-1 times via generate; register 0 has no counter.

Test Plan:
1. Reset then read: read r5 -> rd_data=0, rd_busy=0, issue_ok=1, sb_err=0.
2. Issue r3, then wb r3=0xDEADBEEF 3 cycles later; rd_en[0]=1, rd_addr[0]=3:
   - stall=1 for cycles 1-2, stall=0 in the wb cycle.
   - rd_data=0xDEADBEEF in the wb cycle via bypass; with the macro off, visible the next cycle and stall one cycle longer.
3. Issue r7 three times (PEND_W=2) -> issue_ok=0 on the 4th attempt; that attempt is dropped and sb_err=1. Issue plus wb r7 in the same cycle at cnt=3 -> accepted, cnt stays 3.
4. wb r9=0x1234 with cnt[9]=0 -> r9 reads 0x1234 the next cycle, sb_err=1, rd_busy stays 0.
5. Issue r4 and r6, then flush together with issue r8 -> all rd_busy=0 the next cycle, r8 not pending, sb_err=0.
6. Write r0=0xFFFFFFFF, issue r0 -> r0 reads 0, rd_busy=0. Assert rst_n=0 mid-stream with cnt[2]=1 -> cnt cleared, r2 reads 0 immediately.
